// File: rtl/alu_wb_queue.sv
// Writeback queue between the 32-bit ALU and the single-port register file.
// Buffers ALU results and drains them as one or two register writes per entry.
module alu_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rstN,
  input  logic                     i_inValid,
  output logic                     o_inReady,
  input  logic [3:0]               i_inOp,
  input  logic [31:0]              i_inR,
  input  logic [31:0]              i_inR2,
  input  logic [4:0]               i_inRd,
  input  logic                     i_inOf,
  input  logic                     i_inCf,
  input  logic                     i_inEq,
  output logic                     o_wbEn,
  output logic [4:0]               o_wbAddr,
  output logic [31:0]              o_wbData,
  input  logic                     i_wbAck,
  output logic [2:0]               o_flags,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [3:0]    OP_MUL    = 4'b0011;
  localparam logic [3:0]    OP_DIV    = 4'b0100;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_BEAT0,
    S_BEAT1
  } state_t;

  logic [3:0]    r_op    [DEPTH];
  logic [31:0]   r_r     [DEPTH];
  logic [31:0]   r_r2    [DEPTH];
  logic [4:0]    r_rd    [DEPTH];
  logic [2:0]    r_fl    [DEPTH];

  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_count;
  logic [2:0]    r_flags;
  state_t        r_state;
  state_t        w_nextState;

  logic          w_enq;
  logic          w_headTwo;
  logic [4:0]    w_beatAddr;
  logic          w_live;
  logic          w_beatDone;
  logic          w_lastBeat;
  logic          w_pop;
  logic          w_moreAfterPop;

  // Ready comes only from the registered count, so a pop never lets a full queue accept.
  assign o_inReady = i_rstN && (r_count != CNT_FULL);
  assign w_enq     = i_inValid && o_inReady;

  assign w_headTwo  = (r_op[r_rdPtr] == OP_MUL) || (r_op[r_rdPtr] == OP_DIV);
  assign w_beatAddr = (r_state == S_BEAT1) ? (r_rd[r_rdPtr] + 5'd1) : r_rd[r_rdPtr];
  assign w_live     = (r_state != S_EMPTY) && (w_beatAddr != 5'd0);

  // A beat to r0 is dead: it burns one cycle without waiting for an ack.
  assign w_beatDone = (r_state != S_EMPTY) && (!w_live || i_wbAck);
  assign w_lastBeat = (r_state == S_BEAT1) || ((r_state == S_BEAT0) && !w_headTwo);
  assign w_pop      = w_beatDone && w_lastBeat;
  assign w_moreAfterPop = (r_count > CNT_ONE) || w_enq;

  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_op[r_wrPtr] <= i_inOp;
      r_r[r_wrPtr]  <= i_inR;
      r_r2[r_wrPtr] <= i_inR2;
      r_rd[r_wrPtr] <= i_inRd;
      r_fl[r_wrPtr] <= {i_inOf, i_inCf, i_inEq};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_flags <= '0;
    end else begin
      if (w_enq) begin
        r_wrPtr <= r_wrPtr + PTR_ONE;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
        r_flags <= r_fl[r_rdPtr];
      end
      if (w_enq && !w_pop) begin
        r_count <= r_count + CNT_ONE;
      end else if (!w_enq && w_pop) begin
        r_count <= r_count - CNT_ONE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_EMPTY: begin
        if (w_enq) begin
          w_nextState = S_BEAT0;
        end
      end
      S_BEAT0: begin
        if (w_beatDone) begin
          if (w_headTwo) begin
            w_nextState = S_BEAT1;
          end else if (w_moreAfterPop) begin
            w_nextState = S_BEAT0;
          end else begin
            w_nextState = S_EMPTY;
          end
        end
      end
      S_BEAT1: begin
        if (w_beatDone) begin
          w_nextState = w_moreAfterPop ? S_BEAT0 : S_EMPTY;
        end
      end
      default: w_nextState = S_EMPTY;
    endcase
  end

  always_comb begin
    o_wbEn   = w_live;
    o_wbAddr = w_beatAddr;
    o_wbData = (r_state == S_BEAT1) ? r_r2[r_rdPtr] : r_r[r_rdPtr];
  end

  assign o_flags = r_flags;
  assign o_count = r_count;
  assign o_busy  = (r_count != '0);

endmodule

// File: tb/tb_alu_wb_queue.sv
// Self-checking bench for alu_wb_queue: directed scenarios plus random traffic,
// compared against a queue-of-register-writes reference model.
module tb_alu_wb_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rstN;
  logic          inValid;
  logic          inReady;
  logic [3:0]    inOp;
  logic [31:0]   inR;
  logic [31:0]   inR2;
  logic [4:0]    inRd;
  logic          inOf;
  logic          inCf;
  logic          inEq;
  logic          wbEn;
  logic [4:0]    wbAddr;
  logic [31:0]   wbData;
  logic          wbAck;
  logic [2:0]    flags;
  logic [CW-1:0] count;
  logic          busy;

  alu_wb_queue #(.DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rstN(rstN), .i_inValid(inValid), .o_inReady(inReady),
    .i_inOp(inOp), .i_inR(inR), .i_inR2(inR2), .i_inRd(inRd),
    .i_inOf(inOf), .i_inCf(inCf), .i_inEq(inEq),
    .o_wbEn(wbEn), .o_wbAddr(wbAddr), .o_wbData(wbData), .i_wbAck(wbAck),
    .o_flags(flags), .o_count(count), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: every queued result expands into its register writes.
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    bit          last;
    logic [2:0]  fl;
  } beat_t;

  beat_t beats[$];
  int    mCount;
  logic [2:0] mFlags;
  int    nChecks;
  int    nFails;

  function automatic bit expEn();
    if (beats.size() == 0) return 1'b0;
    return beats[0].addr != 5'd0;
  endfunction

  function automatic bit expReady();
    return rstN && (mCount < DEPTH);
  endfunction

  function automatic logic [3:0] randSingleOp();
    logic [3:0] op;
    do op = 4'($urandom_range(0, 15)); while (op == 4'd3 || op == 4'd4);
    return op;
  endfunction

  task automatic driveEntry(input logic [3:0] op, input logic [31:0] r, input logic [31:0] r2,
                            input logic [4:0] rd, input logic [2:0] fl);
    inOp = op; inR = r; inR2 = r2; inRd = rd;
    {inOf, inCf, inEq} = fl;
  endtask

  task automatic driveRandom(input logic [3:0] op, input logic [4:0] rd);
    driveEntry(op, $urandom, $urandom, rd, 3'($urandom_range(0, 7)));
  endtask

  // One clock edge: the model takes the same inputs the DUT sees, then outputs settle.
  task automatic tick();
    int    cntBefore;
    bit    acc;
    bit    two;
    beat_t b;
    @(posedge clk);
    cntBefore = mCount;
    if (!rstN) begin
      beats.delete();
      mCount = 0;
      mFlags = 3'b000;
    end else begin
      acc = inValid && (cntBefore < DEPTH);
      if (beats.size() > 0) begin
        b = beats[0];
        if (b.addr == 5'd0 || wbAck) begin
          void'(beats.pop_front());
          if (b.last) begin
            mCount = mCount - 1;
            mFlags = b.fl;
          end
        end
      end
      if (acc) begin
        two = (inOp == 4'd3) || (inOp == 4'd4);
        beats.push_back('{addr: inRd, data: inR, last: !two, fl: {inOf, inCf, inEq}});
        if (two) beats.push_back('{addr: inRd + 5'd1, data: inR2, last: 1'b1, fl: {inOf, inCf, inEq}});
        mCount = mCount + 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rstN = 1'b0; inValid = 1'b0; wbAck = 1'b0;
    driveEntry(4'd0, 32'd0, 32'd0, 5'd0, 3'b000);
    tick();
    tick();
    nChecks++;
    if (inReady !== 1'b0 || wbEn !== 1'b0) begin
      nFails++; $display("[TB] FAIL reset_outputs ready=%0b wbEn=%0b required 0/0", inReady, wbEn);
    end
    nChecks++;
    if (count !== '0 || flags !== 3'b000 || busy !== 1'b0) begin
      nFails++; $display("[TB] FAIL reset_state count=%0d flags=%b busy=%0b required 0/000/0", count, flags, busy);
    end
    rstN = 1'b1;
    #1;
    nChecks++;
    if (inReady !== 1'b1) begin
      nFails++; $display("[TB] FAIL ready_after_reset got %0b required 1", inReady);
    end
  endtask

  task automatic test_single_write();
    inValid = 1'b1; wbAck = 1'b0;
    driveEntry(4'b0101, 32'h0000_0007, 32'h0, 5'd3, 3'b010);
    tick();
    inValid = 1'b0;
    nChecks++;
    if (wbEn !== 1'b1 || wbAddr !== 5'd3 || wbData !== 32'd7) begin
      nFails++; $display("[TB] FAIL single_beat en=%0b addr=%0d data=%h required 1/3/7", wbEn, wbAddr, wbData);
    end
    tick();
    nChecks++;
    if (wbEn !== 1'b1 || count !== CW'(1)) begin
      nFails++; $display("[TB] FAIL single_hold en=%0b count=%0d required 1/1", wbEn, count);
    end
    wbAck = 1'b1;
    tick();
    wbAck = 1'b0;
    nChecks++;
    if (flags !== 3'b010 || count !== '0 || wbEn !== 1'b0) begin
      nFails++; $display("[TB] FAIL single_retire flags=%b count=%0d en=%0b required 010/0/0", flags, count, wbEn);
    end
  endtask

  task automatic test_two_beat();
    wbAck = 1'b1; inValid = 1'b1;
    driveEntry(4'b0011, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5'd8, 3'b101);
    tick();
    inValid = 1'b0;
    nChecks++;
    if (wbEn !== 1'b1 || wbAddr !== 5'd8 || wbData !== 32'hFFFF_FFFE) begin
      nFails++; $display("[TB] FAIL mul_beat0 en=%0b addr=%0d data=%h required 1/8/fffffffe", wbEn, wbAddr, wbData);
    end
    tick();
    nChecks++;
    if (wbEn !== 1'b1 || wbAddr !== 5'd9 || wbData !== 32'hFFFF_FFFF || count !== CW'(1)) begin
      nFails++; $display("[TB] FAIL mul_beat1 en=%0b addr=%0d data=%h count=%0d required 1/9/ffffffff/1", wbEn, wbAddr, wbData, count);
    end
    tick();
    nChecks++;
    if (count !== '0 || wbEn !== 1'b0 || flags !== 3'b101) begin
      nFails++; $display("[TB] FAIL mul_pop count=%0d en=%0b flags=%b required 0/0/101", count, wbEn, flags);
    end
  endtask

  task automatic test_zero_reg();
    wbAck = 1'b1;
    inValid = 1'b1;
    driveEntry(4'b0100, 32'hAAAA_0001, 32'hBBBB_0002, 5'd31, 3'b001);
    tick();
    inValid = 1'b0;
    nChecks++;
    if (wbEn !== 1'b1 || wbAddr !== 5'd31 || wbData !== 32'hAAAA_0001) begin
      nFails++; $display("[TB] FAIL div_rd31_beat0 en=%0b addr=%0d data=%h required 1/31/aaaa0001", wbEn, wbAddr, wbData);
    end
    tick();
    nChecks++;
    if (wbEn !== 1'b0 || count !== CW'(1)) begin
      nFails++; $display("[TB] FAIL div_rd31_dead en=%0b count=%0d required 0/1", wbEn, count);
    end
    tick();
    nChecks++;
    if (count !== '0 || flags !== 3'b001) begin
      nFails++; $display("[TB] FAIL div_rd31_pop count=%0d flags=%b required 0/001", count, flags);
    end

    inValid = 1'b1;
    driveEntry(4'b0111, 32'h1234_5678, 32'h0, 5'd0, 3'b110);
    tick();
    inValid = 1'b0;
    nChecks++;
    if (wbEn !== 1'b0 || count !== CW'(1)) begin
      nFails++; $display("[TB] FAIL rd0_dead en=%0b count=%0d required 0/1", wbEn, count);
    end
    tick();
    nChecks++;
    if (count !== '0 || flags !== 3'b110) begin
      nFails++; $display("[TB] FAIL rd0_pop count=%0d flags=%b required 0/110", count, flags);
    end

    inValid = 1'b1;
    driveEntry(4'b0011, 32'h5555_5555, 32'h6666_6666, 5'd0, 3'b011);
    tick();
    inValid = 1'b0;
    nChecks++;
    if (wbEn !== 1'b0) begin
      nFails++; $display("[TB] FAIL mul_rd0_dead en=%0b required 0", wbEn);
    end
    tick();
    nChecks++;
    if (wbEn !== 1'b1 || wbAddr !== 5'd1 || wbData !== 32'h6666_6666) begin
      nFails++; $display("[TB] FAIL mul_rd0_beat1 en=%0b addr=%0d data=%h required 1/1/66666666", wbEn, wbAddr, wbData);
    end
    tick();
    nChecks++;
    if (count !== '0 || wbEn !== 1'b0) begin
      nFails++; $display("[TB] FAIL mul_rd0_pop count=%0d en=%0b required 0/0", count, wbEn);
    end
  endtask

  task automatic test_backpressure();
    logic [4:0]  holdAddr;
    logic [31:0] holdData;
    wbAck = 1'b0;
    for (int i = 0; i < 5; i++) begin
      inValid = 1'b1;
      driveRandom(4'($urandom_range(0, 15)), 5'($urandom_range(1, 30)));
      tick();
      nChecks++;
      if (count !== CW'(mCount) || inReady !== expReady()) begin
        nFails++; $display("[TB] FAIL fill_%0d count=%0d ready=%0b required %0d/%0b", i, count, inReady, mCount, expReady());
      end
    end
    inValid = 1'b0;
    nChecks++;
    if (inReady !== 1'b0 || count !== CW'(DEPTH)) begin
      nFails++; $display("[TB] FAIL full_state ready=%0b count=%0d required 0/%0d", inReady, count, DEPTH);
    end
    holdAddr = beats[0].addr;
    holdData = beats[0].data;
    for (int i = 0; i < 6; i++) begin
      wbAck = 1'b0;
      tick();
      nChecks++;
      if (wbEn !== 1'b1 || wbAddr !== holdAddr || wbData !== holdData || inReady !== 1'b0) begin
        nFails++; $display("[TB] FAIL full_hold en=%0b addr=%0d data=%h ready=%0b required 1/%0d/%h/0", wbEn, wbAddr, wbData, inReady, holdAddr, holdData);
      end
    end
    wbAck = 1'b1;
    for (int i = 0; i < 4 * DEPTH && mCount > 0; i++) begin
      tick();
      nChecks++;
      if (wbEn !== expEn() || inReady !== expReady() || count !== CW'(mCount)) begin
        nFails++; $display("[TB] FAIL drain en=%0b ready=%0b count=%0d required %0b/%0b/%0d", wbEn, inReady, count, expEn(), expReady(), mCount);
      end else if (expEn() && (wbAddr !== beats[0].addr || wbData !== beats[0].data)) begin
        nFails++; $display("[TB] FAIL drain_order addr=%0d data=%h required %0d/%h", wbAddr, wbData, beats[0].addr, beats[0].data);
      end
    end
    nChecks++;
    if (count !== '0 || mCount != 0) begin
      nFails++; $display("[TB] FAIL drain_timeout count=%0d model=%0d required 0/0", count, mCount);
    end
  endtask

  task automatic test_back_to_back();
    wbAck = 1'b0;
    for (int i = 0; i < 2; i++) begin
      inValid = 1'b1;
      driveRandom(randSingleOp(), 5'($urandom_range(1, 31)));
      tick();
    end
    wbAck = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      inValid = 1'b1;
      driveRandom(randSingleOp(), 5'($urandom_range(1, 31)));
      tick();
      nChecks++;
      if (count !== CW'(2) || wbEn !== 1'b1) begin
        nFails++; $display("[TB] FAIL b2b_count count=%0d en=%0b required 2/1", count, wbEn);
      end else if (wbAddr !== beats[0].addr || wbData !== beats[0].data || flags !== mFlags) begin
        nFails++; $display("[TB] FAIL b2b_data addr=%0d data=%h flags=%b required %0d/%h/%b", wbAddr, wbData, flags, beats[0].addr, beats[0].data, mFlags);
      end
    end
    inValid = 1'b0;
    for (int i = 0; i < 4 * DEPTH && mCount > 0; i++) begin
      tick();
    end
    nChecks++;
    if (count !== '0 || busy !== 1'b0 || flags !== mFlags) begin
      nFails++; $display("[TB] FAIL b2b_drain count=%0d busy=%0b flags=%b required 0/0/%b", count, busy, flags, mFlags);
    end
  endtask

  task automatic test_random();
    logic [4:0] rd;
    for (int i = 0; i < 300; i++) begin
      inValid = ($urandom_range(0, 1) == 1);
      wbAck   = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0: rd = 5'd0;
        1: rd = 5'd31;
        default: rd = 5'($urandom_range(0, 31));
      endcase
      driveRandom(4'($urandom_range(0, 15)), rd);
      tick();
      nChecks++;
      if (wbEn !== expEn() || inReady !== expReady() || count !== CW'(mCount) ||
          flags !== mFlags || busy !== (mCount != 0)) begin
        nFails++; $display("[TB] FAIL rand_ctrl cyc=%0d en=%0b ready=%0b count=%0d flags=%b required %0b/%0b/%0d/%b",
                           i, wbEn, inReady, count, flags, expEn(), expReady(), mCount, mFlags);
      end else if (expEn() && (wbAddr !== beats[0].addr || wbData !== beats[0].data)) begin
        nFails++; $display("[TB] FAIL rand_data cyc=%0d addr=%0d data=%h required %0d/%h", i, wbAddr, wbData, beats[0].addr, beats[0].data);
      end
    end
    inValid = 1'b0;
    wbAck = 1'b1;
    for (int i = 0; i < 4 * DEPTH && mCount > 0; i++) begin
      tick();
    end
    nChecks++;
    if (count !== '0 || mCount != 0 || flags !== mFlags) begin
      nFails++; $display("[TB] FAIL rand_drain count=%0d model=%0d flags=%b required 0/0/%b", count, mCount, flags, mFlags);
    end
  endtask

  task automatic test_reset_mid_beat();
    wbAck = 1'b0;
    inValid = 1'b1;
    driveEntry(4'b0011, 32'hCAFE_0000, 32'hCAFE_0001, 5'd10, 3'b111);
    tick();
    driveRandom(randSingleOp(), 5'd12);
    tick();
    driveRandom(4'b0100, 5'd14);
    tick();
    inValid = 1'b0;
    wbAck = 1'b1;
    tick();
    nChecks++;
    if (wbEn !== 1'b1 || wbAddr !== 5'd11 || wbData !== 32'hCAFE_0001 || count !== CW'(3)) begin
      nFails++; $display("[TB] FAIL pre_reset_beat1 en=%0b addr=%0d data=%h count=%0d required 1/11/cafe0001/3", wbEn, wbAddr, wbData, count);
    end
    wbAck = 1'b0;
    rstN = 1'b0;
    tick();
    nChecks++;
    if (wbEn !== 1'b0 || count !== '0 || flags !== 3'b000 || inReady !== 1'b0) begin
      nFails++; $display("[TB] FAIL mid_reset en=%0b count=%0d flags=%b ready=%0b required 0/0/000/0", wbEn, count, flags, inReady);
    end
    rstN = 1'b1;
    wbAck = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      nChecks++;
      if (wbEn !== 1'b0 || count !== '0 || inReady !== 1'b1) begin
        nFails++; $display("[TB] FAIL post_reset_quiet en=%0b count=%0d ready=%0b required 0/0/1", wbEn, count, inReady);
      end
    end
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    mCount  = 0;
    mFlags  = 3'b000;
    test_reset();
    test_single_write();
    test_two_beat();
    test_zero_reg();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_beat();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/alu_wb_queue.md
# alu_wb_queue

Writeback queue directly downstream of the 32-bit ALU. It buffers ALU results (R, R2, OF/CF/EQ) with a valid/ready handshake and drains them to the single-write-port register file. Multiply (OP 0011) and divide (OP 0100) results are split into two write beats: R goes to rd and R2 to rd+1. The ALU never stalls on a busy write port unless the queue is full.

## Interface
- DEPTH, 4, number of queued results; power of two, ≥2
- CLK  in  1  rising-edge clock
- RST_N  in  1  synchronous reset, active-low
- IN_VALID  in  1  ALU result valid
- IN_READY  out  1  queue can accept a result (=!full; 0 while RST_N low)
- IN_OP  in  4  ALU opcode of the result
- IN_R  in  32  ALU primary result
- IN_R2  in  32  ALU secondary result (mult high / div remainder)
- IN_RD  in  5  destination register index
- IN_OF, IN_CF, IN_EQ  in  1 each  ALU flags
- WB_EN  out  1  register-file write request
- WB_ADDR  out  5  write address
- WB_DATA  out  32  write data
- WB_ACK  in  1  register file accepted the write this cycle
- FLAGS  out  3  {OF,CF,EQ} of the last fully retired entry
- COUNT  out  clog2(DEPTH)+1  occupied entries
- BUSY  out  1  COUNT≠0

## Operation
- Enqueue happens on IN_VALID & IN_READY at a rising edge. The entry stores OP, R, R2, RD and the three flags.
- IN_READY depends only on the registered COUNT. A dequeue in the same cycle does not raise it (no full-pass-through).
- Head sequencer states:
  - EMPTY: COUNT=0.
  - BEAT0: address RD, data R.
  - BEAT1: address (RD+1) mod 32, data R2. Entered only for OP 0011/0100.
  - All other OPs, including the undefined 1101–1111, are single-beat.
- A beat is *live* when its address ≠0. A live beat drives WB_EN=1 with WB_ADDR/WB_DATA combinationally from the head entry and state.
  - It holds until a cycle with WB_ACK=1, then advances.
- A beat whose address is 0 is *dead*: WB_EN=0, one cycle is consumed, and no ack is required.
  - RD=0 kills BEAT0.
  - RD=31 on a two-beat op kills BEAT1 (wraps to 0).
- WB_ACK while WB_EN=0 is ignored.
- When the last beat of the head completes:
  - The entry pops and COUNT decrements.
  - FLAGS loads that entry's flags.
  - The sequencer goes to BEAT0 of the next entry, or EMPTY.
- Simultaneous enqueue and pop leaves COUNT unchanged. Both pointers advance and wrap modulo DEPTH.
- WB_ADDR and WB_DATA are don't-care while WB_EN=0. The bench checks them only when WB_EN=1.

## Timing
- Reset (RST_N=0 at an edge) sets:
  - pointers=0, COUNT=0, state=EMPTY, FLAGS=000
  - WB_EN=0 and IN_READY=0 (the latter combinationally while RST_N low)
- IN_READY=1 in the first cycle after RST_N returns high.
- Reset mid-operation discards all entries, including a half-written two-beat entry. No further WB_EN is issued for them.
- Latency: an entry accepted at edge N drives its first beat in cycle N+1. There is no input-to-output bypass.
- Best-case throughput with WB_ACK tied high:
  - one single-beat entry per cycle
  - two cycles per mult/div entry
- Dead beats cost exactly one cycle each.
- A full queue with WB_ACK held low keeps all outputs stable indefinitely. IN_READY stays 0.

## Test plan
- Reset and single write: after reset, IN_READY=1, WB_EN=0, FLAGS=000. Enqueue OP=0101, R=0x0000_0007, RD=3, CF=1. Expected:
  - next cycle WB_EN=1, WB_ADDR=3, WB_DATA=7
  - after WB_ACK, FLAGS=010 and COUNT=0
- Two-beat split: enqueue OP=0011, R=0xFFFF_FFFE, R2=0xFFFF_FFFF, RD=8 with WB_ACK tied high. Expected:
  - cycle 1: addr 8 / 0xFFFF_FFFE
  - cycle 2: addr 9 / 0xFFFF_FFFF
  - pop after cycle 2
- Zero-register suppression, three cases:
  - OP=0100, RD=31: writes only addr 31 (R), then one dead cycle.
  - OP=0111, RD=0: one cycle with WB_EN=0, then pop.
  - OP=0011, RD=0: dead beat, then addr 1 / R2.
- Backpressure and full: with WB_ACK=0, enqueue 5 results. Expected:
  - IN_READY drops after the 4th; COUNT=4; outputs hold the first entry.
  - After releasing WB_ACK, writes come out in enqueue order.
  - IN_READY rises one cycle after the first pop.
- Simultaneous enqueue/pop: at COUNT=2, enqueue while the head retires. Expected:
  - COUNT stays 2.
  - Pointer wrap-around is exercised over ≥2×DEPTH entries with no data loss or reordering.
- Reset mid-beat: assert RST_N=0 during BEAT1 of a two-beat entry with 3 entries queued. Expected:
  - WB_EN=0 next cycle, COUNT=0, FLAGS=000.
  - No further writes for the discarded entries.
